// File: rtl/cpu_pkg.sv
// Constants shared by the MEM/WB pipeline buffer and the write-back register file.
package cpu_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam logic [4:0] REG_ZERO = 5'd0;
  // MuxD polarity of wb_mem_to_reg; the MEM/WB buffer drives it with the same encoding.
  localparam logic WB_SEL_ALU = 1'b0;
  localparam logic WB_SEL_MEM = 1'b1;
endpackage

// File: rtl/regfile_bypass_rd.sv
// One asynchronous register-file read port.
// Priority: r0 reads zero, then same-cycle write-back bypass, then the array.
module regfile_bypass_rd #(
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int ADDR_W   = cpu_pkg::ADDR_W,
  parameter int NUM_REGS = 2 ** ADDR_W
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              wbWe,
  input  logic [ADDR_W-1:0] wbRd,
  input  logic [DATA_W-1:0] wbValue,
  input  logic [DATA_W-1:0] regs [NUM_REGS],
  output logic [DATA_W-1:0] rdData
);
  import cpu_pkg::*;

  always_comb begin
    rdData = regs[addr];
    if (addr == ADDR_W'(REG_ZERO)) begin
      rdData = '0;
    end else if (wbWe && (addr == wbRd)) begin
      rdData = wbValue;
    end
  end
endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: selects the MEM/WB result, commits it to the 32x32 register
// file, serves two bypassed decode read ports and counts retired instructions.
module wb_regfile #(
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int ADDR_W   = cpu_pkg::ADDR_W,
  parameter int NUM_REGS = 2 ** ADDR_W,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  input  logic              wb_reg_write,
  input  logic              wb_mem_to_reg,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_mem_data,
  input  logic [DATA_W-1:0] wb_alu_res,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] wb_value,
  output logic              wb_we,
  output logic [CNT_W-1:0]  retired_count
);
  import cpu_pkg::*;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [CNT_W-1:0]  retiredCnt;

  assign wb_value = (wb_mem_to_reg == WB_SEL_MEM) ? wb_mem_data : wb_alu_res;
  // Gating with rst_n keeps a reset-cycle write from bypassing onto the read ports.
  assign wb_we    = rst_n & wb_valid & wb_reg_write & (wb_rd != ADDR_W'(REG_ZERO));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_we) begin
      regs[wb_rd] <= wb_value;
    end
  end

  // Bubbles do not retire; stores and branches do, whatever wb_reg_write says.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retiredCnt <= '0;
    end else if (wb_valid) begin
      retiredCnt <= retiredCnt + 1'b1;
    end
  end

  assign retired_count = retiredCnt;

  regfile_bypass_rd #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)
  ) uRsPort (
    .addr(rs_addr), .wbWe(wb_we), .wbRd(wb_rd), .wbValue(wb_value),
    .regs(regs), .rdData(rs_data)
  );

  regfile_bypass_rd #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)
  ) uRtPort (
    .addr(rt_addr), .wbWe(wb_we), .wbRd(wb_rd), .wbValue(wb_value),
    .regs(regs), .rdData(rt_data)
  );
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back consumer of the MEM/WB pipeline register.
- Selects the write-back value (data memory or ALU result), commits it to a 32x32 general-purpose register file, and serves two combinational decode-stage read ports with write-before-read bypass.
- Also counts retired instructions for debug and performance visibility.
- Sits between the MEM/WB buffer outputs and the ID-stage operand fetch.

Parameters:
- DATA_W, 32, register and data width in bits.
- ADDR_W, 5, register address width.
- NUM_REGS, 32, number of architectural registers (2**ADDR_W).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  pipeline clock, rising-edge active.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- wb_valid  in  1  MEM/WB slot holds a real instruction (0 = bubble).
- wb_reg_write  in  1  instruction writes a register.
- wb_mem_to_reg  in  1  write-back select: 1 = memory data, 0 = ALU result.
- wb_rd  in  ADDR_W  destination register index.
- wb_mem_data  in  DATA_W  data-memory read value from MEM/WB.
- wb_alu_res  in  DATA_W  ALU result from MEM/WB.
- rs_addr  in  ADDR_W  read port A index.
- rt_addr  in  ADDR_W  read port B index.
- rs_data  out  DATA_W  read port A data (combinational).
- rt_data  out  DATA_W  read port B data (combinational).
- wb_value  out  DATA_W  selected write-back value (combinational).
- wb_we  out  1  effective write enable this cycle (combinational).
- retired_count  out  CNT_W  registered count of retired instructions.

Behaviour:
- wb_value = wb_mem_to_reg ? wb_mem_data : wb_alu_res.
- wb_we = rst_n & wb_valid & wb_reg_write & (wb_rd != 0).
- Write: on the rising edge of clk, when wb_we = 1, regs[wb_rd] <= wb_value. Write latency is 1 cycle to array state.
- Register 0 is hardwired to zero.
  - Never written.
  - Reads of index 0 always return 0, including while bypass conditions hold.
- Read ports are asynchronous, with this priority:
  - index 0 -> 0;
  - else if wb_we and index == wb_rd -> wb_value (same-cycle bypass);
  - else regs[index].
- Both read ports may address the same register, or the register being written, simultaneously. Each port resolves independently.
- wb_valid = 0 (bubble): no write and no count increment, regardless of the other control inputs.
- retired_count increments by 1 on each rising edge with rst_n = 1 and wb_valid = 1.
  - The increment is independent of wb_reg_write, so stores and branches count.
  - Wraps from 2**CNT_W-1 to 0 with no flag.
- Reset: on a rising edge with rst_n = 0:
  - all regs[1..NUM_REGS-1] <= 0 in that single cycle;
  - retired_count <= 0.
- Reset priority:
  - Reset overrides a simultaneous write and increment.
  - Combinational outputs during reset: wb_we = 0, so reads return stored values with no bypass.
- Reset mid-stream: a write presented in the same cycle as reset is lost. The first write after rst_n returns high takes effect normally.
- No X propagation from unwritten registers: all array entries are defined by reset.
- Undefined control inputs (X) are a bench error, not a design case.

Decomposition:
- Shared package cpu_pkg holds:
  - DATA_W and ADDR_W constants;
  - REG_ZERO = 5'd0;
  - the write-back select encoding WB_SEL_ALU = 1'b0, WB_SEL_MEM = 1'b1, so the MEM/WB buffer and this block agree on MuxD polarity.
- One sub-module is natural: regfile_bypass_rd. It is the read-port resolver (zero check, bypass compare, array read) and is instantiated twice, once for rs and once for rt.
- Array, counter and write-back mux stay in the top level.

Test Plan:
- Reset then read all 32 indices on both ports -> every rs_data/rt_data = 0, retired_count = 0.
- wb_valid=1, reg_write=1, mem_to_reg=0, rd=5, alu_res=0x0000_00AA, mem_data=0xDEAD_BEEF, rs_addr=5 in the same cycle:
  - in-cycle: wb_value = 0xAA, rs_data = 0xAA via bypass;
  - next cycle with no write: rs_data = 0xAA from the array; retired_count = 1.
- Write rd=0 with mem_to_reg=1, mem_data=0x1234_5678 and rs_addr=rt_addr=0:
  - wb_we = 0; both ports read 0 in-cycle and after the edge;
  - retired_count still increments.
- Bubble: wb_valid=0, reg_write=1, rd=7, alu_res=0x55 -> r7 unchanged (0), retired_count unchanged.
- Reset collision: write r3=0x77 with rst_n=0 on the same edge -> r3 = 0, retired_count = 0; the next valid write r3=0x88 reads back 0x88.
- Preload retired_count to 0xFFFF_FFFF (force or long run), then one valid cycle -> retired_count = 0.
